// File: rtl/id_branch_hazard_ctrl.sv
// rtl/id_branch_hazard_ctrl.sv - decode-stage branch/jump hazard stall and operand forward control
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall_cycles/stall_events counters.
module id_branch_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic                      id_branch,
  input  logic                      id_jump,
  input  logic                      id_flush,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_addr,
  input  logic                      ex_valid,
  input  logic [REG_AW-1:0]         ex_rd_addr,
  input  logic [4:0]                ex_opcode,
  input  logic                      mem_valid,
  input  logic [REG_AW-1:0]         mem_rd_addr,
  input  logic [4:0]                mem_opcode,
  input  logic                      wb_valid,
  input  logic [REG_AW-1:0]         wb_rd_addr,
  input  logic                      wb_regwrite,
  output logic                      stall,
  output logic [NUM_SRC*3-1:0]      fwd_sel,
  output logic                      busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [15:0]               stall_events
`endif
);

  localparam logic [4:0] OP_LOAD  = 5'h00;
  localparam logic [4:0] OP_ARI_I = 5'h04;
  localparam logic [4:0] OP_AUIPC = 5'h05;
  localparam logic [4:0] OP_ARI_R = 5'h0C;
  localparam logic [4:0] OP_LUI   = 5'h0D;
  localparam logic [4:0] OP_JALR  = 5'h19;
  localparam logic [4:0] OP_JAL   = 5'h1B;

  typedef enum logic {RUN, STALL} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               busy_q;
  logic               active;
  logic [CNT_W-1:0]   req;
  logic [NUM_SRC*3-1:0] fwd_comb;

  function automatic logic is_writer(input logic [4:0] op);
    return (op == OP_ARI_I) || (op == OP_ARI_R) || (op == OP_LUI) || (op == OP_AUIPC) ||
           (op == OP_JAL) || (op == OP_JALR) || (op == OP_LOAD);
  endfunction

  assign active = (id_branch | id_jump) & id_valid & ~id_flush;

  // EX shadows MEM, MEM shadows WB; req is the worst case over all sources.
  always_comb begin
    logic [REG_AW-1:0] rs;
    logic              nz, ex_hit, mem_hit, wb_hit;
    logic [CNT_W-1:0]  src_req;
    logic [2:0]        sel;
    req      = '0;
    fwd_comb = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs      = id_rs_addr[i*REG_AW +: REG_AW];
      nz      = (rs != '0);
      ex_hit  = ex_valid & (ex_rd_addr == rs) & nz & is_writer(ex_opcode);
      mem_hit = mem_valid & (mem_rd_addr == rs) & nz & is_writer(mem_opcode);
      wb_hit  = wb_valid & (wb_rd_addr == rs) & nz & wb_regwrite;
      src_req = '0;
      sel     = 3'b000;
      if (ex_hit) begin
        src_req = (ex_opcode == OP_LOAD) ? CNT_W'(1 + LOAD_LAT) : CNT_W'(1);
      end else if (mem_hit) begin
        case (mem_opcode)
          OP_LOAD:          src_req = CNT_W'(LOAD_LAT);
          OP_ARI_I, OP_ARI_R: sel = 3'b001;
          OP_LUI:           sel = 3'b010;
          OP_AUIPC:         sel = 3'b011;
          default:          sel = 3'b100;
        endcase
      end else if (wb_hit) begin
        sel = 3'b110;
      end
      if (src_req > req) req = src_req;
      fwd_comb[i*3 +: 3] = sel;
    end
  end

  assign stall   = rst_n & ~id_flush & ((state == RUN) ? (active & (req != '0)) : 1'b1);
  assign fwd_sel = (rst_n && state == RUN && active) ? fwd_comb : '0;
  assign busy    = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (id_flush) begin
      state  <= RUN;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (active && req > CNT_W'(1)) begin
            state  <= STALL;
            cnt    <= req - CNT_W'(1);
            busy_q <= 1'b1;
          end
        end
        default: begin
          if (cnt == CNT_W'(1)) begin
            state  <= RUN;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q      <= 1'b0;
      stall_cycles <= '0;
      stall_events <= '0;
    end else begin
      stall_q <= stall;
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (state == RUN && stall && !stall_q && stall_events != '1)
        stall_events <= stall_events + 16'd1;
    end
  end
`endif

endmodule

// File: doc/id_branch_hazard_ctrl.md
Name: id_branch_hazard_ctrl

Overview:
ID-stage hazard and forwarding controller for branches and jumps that resolve in decode. It generalises the single-stage, two-operand check to NUM_SRC operands and three producer stages (ID/EX, EX/MEM, MEM/WB). A counter-driven stall FSM covers multi-cycle load latency. It sits beside the decode comparator and drives its operand muxes and the IF/ID stall.

Parameters:
REG_AW, 5, register address width
NUM_SRC, 2, number of decode source operands checked
LOAD_LAT, 1, extra cycles (>=1) after EX/MEM before load data is forwardable from MEM/WB
CNT_W, 3, stall counter width; must hold 1+LOAD_LAT

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode slot holds a valid instruction
id_branch  in  1  decode instruction is a conditional branch
id_jump  in  1  decode instruction is JAL/JALR
id_flush  in  1  abort decode instruction (redirect/exception)
id_rs_addr  in  NUM_SRC*REG_AW  packed source addresses, src i at [i*REG_AW +: REG_AW]
ex_valid  in  1  ID/EX register valid
ex_rd_addr  in  REG_AW  ID/EX destination
ex_opcode  in  5  ID/EX opcode[6:2]
mem_valid  in  1  EX/MEM register valid
mem_rd_addr  in  REG_AW  EX/MEM destination
mem_opcode  in  5  EX/MEM opcode[6:2]
wb_valid  in  1  MEM/WB register valid
wb_rd_addr  in  REG_AW  MEM/WB destination
wb_regwrite  in  1  MEM/WB writes the register file
stall  out  1  hold PC and IF/ID, bubble into ID/EX
fwd_sel  out  NUM_SRC*3  packed per-source forward select
busy  out  1  FSM in STALL

Behaviour:
- Reset (rst_n low, async): state=RUN, cnt=0, busy=0. stall=0 and fwd_sel=0 while reset is held.
- Active: (id_branch|id_jump) & id_valid & ~id_flush. When inactive, no stall is requested and fwd_sel=0.
- Writer opcodes (`defines.v`): OPCODE_Arith_I, OPCODE_Arith_R, OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR, OPCODE_Load. All other opcodes never match.
- Source i matches stage S when: S valid, S rd==rs_i, rs_i!=0, and S is a writer. For WB, writer means wb_regwrite.
- Per-source required stall cycles, youngest stage first:
  - EX match, load: 1+LOAD_LAT.
  - EX match, non-load: 1.
  - MEM match, load: LOAD_LAT.
  - Otherwise: 0.
- req = maximum over all sources.
- fwd_sel codes per source, combinational, RUN only, youngest-first (MEM checked before WB):
  - 000: register file.
  - 001: MEM ALU (Arith_I/Arith_R).
  - 010: MEM LUI immediate.
  - 011: MEM AUIPC result.
  - 100: MEM PC+4 (JAL/JALR).
  - 101: never driven.
  - 110: WB data (any WB match not shadowed by MEM).
  - A MEM load match yields 000 together with stall=1.
- FSM RUN:
  - stall = active & (req!=0), combinational.
  - If req==1: stay in RUN.
  - If req>1: go to STALL, cnt<=req-1.
- FSM STALL:
  - stall=1, busy=1, fwd_sel=000.
  - cnt decrements each cycle.
  - When cnt==1: next state RUN, cnt<=0.
  - Total stall cycles = req. In the following RUN cycle, hazards are re-evaluated from the current pipeline.
- id_flush in any state: next state RUN, cnt<=0. stall=0 in the flush cycle.
- Simultaneous EX and MEM matches on different sources: the maximum req wins.
- A match on the same register in both EX and MEM is decided by EX.
- rs==0 never stalls or forwards.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs stall_cycles (32 bits, +1 per cycle with stall=1) and stall_events (16 bits, +1 on each RUN cycle where stall rises from 0).
- Both counters saturate and are cleared by rst_n.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Branch rs1=5, MEM Arith_R rd=5, no EX match -> stall=0, fwd_sel[2:0]=001 same cycle.
- Branch rs2=7, EX Arith_I rd=7 -> stall=1 for exactly 1 cycle; next cycle (producer in MEM) fwd_sel[5:3]=001, stall=0.
- LOAD_LAT=1, JALR rs1=3, EX Load rd=3 -> stall for 2 cycles (busy=1 in the second cycle), then fwd_sel[2:0]=110 with WB rd=3.
- Branch rs1=rs2=0, EX Load rd=0 -> stall=0, fwd_sel=0.
- In STALL with cnt=2, pulse id_flush -> stall=0 that cycle, next state RUN, busy=0.
- rst_n asserted mid-STALL -> stall=0, busy=0 immediately without a clock edge; with HAZARD_PERF_CNT_EN defined, the counters read 0.
